// File: rtl/wb_stage_regfile_pkg.sv
// Shared constants, types and helpers for the MIPS write-back stage and register file.
package wb_stage_regfile_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned CNT_W_DEF  = 16;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = REG_ADDR_W'(0);

    // Control half of the MEM/WB stage; the data word is sized by DATA_W at the top.
    typedef struct packed {
        logic      valid;
        logic      wreg;
        reg_addr_t rd;
    } wb_ctrl_t;

    function automatic logic is_zero_reg(input reg_addr_t addr);
        return addr == ZERO_REG;
    endfunction

endpackage

// File: rtl/wb_stage_regfile_regfile_2r1w.sv
// 32-entry register file: one synchronous write port, two combinational read ports.
// Register 0 is hard-wired to zero on both write and read sides.
module regfile_2r1w
    import wb_stage_regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  reg_addr_t         waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  reg_addr_t         raddr_a_i,
    input  reg_addr_t         raddr_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // Array storage: cleared on reset, written on the clock edge, address 0 discarded.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && !is_zero_reg(waddr_i)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = is_zero_reg(raddr_a_i) ? '0 : regs_q[raddr_a_i];
    assign rdata_b_o = is_zero_reg(raddr_b_i) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/wb_stage_regfile.sv
// MIPS write-back stage: MEM/WB staging register, m2reg select, commit into the
// register file and retired-instruction counter.
// Optional macro RF_WRITE_BYPASS_EN forwards the staged write data to the read ports.
module wb_stage_regfile
    import wb_stage_regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              m_valid,
    input  logic              m_wreg,
    input  logic              m_m2reg,
    input  reg_addr_t         m_rd,
    input  logic [DATA_W-1:0] m_alu,
    input  logic [DATA_W-1:0] m_dm,
    input  logic              wb_stall,
    input  reg_addr_t         rs_addr,
    input  reg_addr_t         rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              w_valid,
    output logic              w_wreg,
    output reg_addr_t         w_rd,
    output logic [DATA_W-1:0] w_data,
    output logic [CNT_W-1:0]  retired_count
);

    wb_ctrl_t          ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              commit_c;
    logic              rf_we_c;
    logic [DATA_W-1:0] rf_rs_c, rf_rt_c;

    // Next-state: capture unless stalled; the outgoing instruction commits on the same edge.
    always_comb begin
        ctrl_d   = ctrl_q;
        data_d   = data_q;
        commit_c = ctrl_q.valid & ~wb_stall;
        rf_we_c  = commit_c & ctrl_q.wreg;
        cnt_d    = commit_c ? cnt_q + CNT_W'(1) : cnt_q;
        if (!wb_stall) begin
            ctrl_d.valid = m_valid;
            ctrl_d.wreg  = m_valid & m_wreg;
            ctrl_d.rd    = m_rd;
            data_d       = m_m2reg ? m_dm : m_alu;
        end
    end

    // MEM/WB stage and retired counter registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ctrl_q <= '0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    regfile_2r1w #(
        .DATA_W(DATA_W)
    ) u_rf (
        .clk_i    (clock),
        .rst_ni   (resetn),
        .we_i     (rf_we_c),
        .waddr_i  (ctrl_q.rd),
        .wdata_i  (data_q),
        .raddr_a_i(rs_addr),
        .raddr_b_i(rt_addr),
        .rdata_a_o(rf_rs_c),
        .rdata_b_o(rf_rt_c)
    );

`ifdef RF_WRITE_BYPASS_EN
    // The staged value is what will commit, so it is forwarded even while stalled.
    logic byp_ok_c;
    assign byp_ok_c = ctrl_q.valid & ctrl_q.wreg & ~is_zero_reg(ctrl_q.rd);
    assign rs_data  = (byp_ok_c && (ctrl_q.rd == rs_addr)) ? data_q : rf_rs_c;
    assign rt_data  = (byp_ok_c && (ctrl_q.rd == rt_addr)) ? data_q : rf_rt_c;
`else
    assign rs_data = rf_rs_c;
    assign rt_data = rf_rt_c;
`endif

    assign w_valid       = ctrl_q.valid;
    assign w_wreg        = ctrl_q.wreg;
    assign w_rd          = ctrl_q.rd;
    assign w_data        = data_q;
    assign retired_count = cnt_q;

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Directed self-checking bench for wb_stage_regfile (counter built 4 bits wide to reach the wrap).
module tb_wb_stage_regfile;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    logic              clock;
    logic              resetn;
    logic              m_valid, m_wreg, m_m2reg;
    logic [4:0]        m_rd;
    logic [DATA_W-1:0] m_alu, m_dm;
    logic              wb_stall;
    logic [4:0]        rs_addr, rt_addr;
    logic [DATA_W-1:0] rs_data, rt_data;
    logic              w_valid, w_wreg;
    logic [4:0]        w_rd;
    logic [DATA_W-1:0] w_data;
    logic [CNT_W-1:0]  retired_count;

    int checks;
    int failures;
    int exp_cnt;

`ifdef RF_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    wb_stage_regfile #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .m_valid      (m_valid),
        .m_wreg       (m_wreg),
        .m_m2reg      (m_m2reg),
        .m_rd         (m_rd),
        .m_alu        (m_alu),
        .m_dm         (m_dm),
        .wb_stall     (wb_stall),
        .rs_addr      (rs_addr),
        .rt_addr      (rt_addr),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .w_valid      (w_valid),
        .w_wreg       (w_wreg),
        .w_rd         (w_rd),
        .w_data       (w_data),
        .retired_count(retired_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic v, input logic w, input logic m2r, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] dm);
        m_valid = v; m_wreg = w; m_m2reg = m2r; m_rd = rd; m_alu = alu; m_dm = dm;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        // Commit r9, then stage a write to r10 that the reset must drop.
        drive(1'b1, 1'b1, 1'b0, 5'd9, 32'h0000_0099, 32'h0);
        tick();
        idle();
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'd10, 32'h0000_1010, 32'h0);
        tick();
        @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({w_valid, w_wreg, w_rd} !== 7'd0) begin
            failures++;
            $display("FAIL reset_ctrl: got valid=%0b wreg=%0b rd=%0d, want 0", w_valid, w_wreg, w_rd);
        end
        checks++;
        if (w_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_wdata: got %h want 0", w_data);
        end
        checks++;
        if (retired_count !== 4'd0) begin
            failures++;
            $display("FAIL reset_count: got %0d want 0", retired_count);
        end
        for (int a = 1; a < 32; a++) begin
            rs_addr = 5'(a);
            rt_addr = 5'(a);
            #1;
            checks++;
            if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
                failures++;
                $display("FAIL reset_reg r%0d: got rs=%h rt=%h want 0", a, rs_data, rt_data);
            end
        end
        idle();
        @(negedge clock);
        resetn = 1'b1;
        tick();
        rs_addr = 5'd10;
        rt_addr = 5'd9;
        #1;
        checks++;
        if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_dropped_write: got r10=%h r9=%h want 0", rs_data, rt_data);
        end
        exp_cnt = 0;
    endtask

    task automatic test_load();
        drive(1'b1, 1'b1, 1'b1, 5'd2, 32'h0, 32'hA000_00AA);
        rs_addr = 5'd2;
        tick();
        checks++;
        if (w_data !== 32'hA000_00AA || w_valid !== 1'b1 || w_wreg !== 1'b1 || w_rd !== 5'd2) begin
            failures++;
            $display("FAIL load_stage: got data=%h v=%0b w=%0b rd=%0d want A00000AA 1 1 2",
                     w_data, w_valid, w_wreg, w_rd);
        end
        checks++;
        if (rs_data !== (BYP ? 32'hA000_00AA : 32'h0)) begin
            failures++;
            $display("FAIL load_early_read: got %h want %h", rs_data, BYP ? 32'hA000_00AA : 32'h0);
        end
        idle();
        tick();
        exp_cnt++;
        checks++;
        if (rs_data !== 32'hA000_00AA || retired_count !== 4'(exp_cnt)) begin
            failures++;
            $display("FAIL load_commit: got r2=%h cnt=%0d want A00000AA %0d", rs_data, retired_count, exp_cnt);
        end
        // m2reg=0 selects the ALU result.
        drive(1'b1, 1'b1, 1'b0, 5'd3, 32'h0000_3333, 32'hDEAD_BEEF);
        tick();
        checks++;
        if (w_data !== 32'h0000_3333) begin
            failures++;
            $display("FAIL alu_select: got %h want 00003333", w_data);
        end
        idle();
        tick();
        exp_cnt++;
        rs_addr = 5'd3;
        rt_addr = 5'd3;
        #1;
        checks++;
        if (rs_data !== 32'h0000_3333 || rt_data !== 32'h0000_3333) begin
            failures++;
            $display("FAIL same_addr_read: got rs=%h rt=%h want 00003333", rs_data, rt_data);
        end
    endtask

    task automatic test_r0();
        drive(1'b1, 1'b1, 1'b0, 5'd0, 32'h1234_5678, 32'h0);
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        tick();
        checks++;
        if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
            failures++;
            $display("FAIL r0_staged: got rs=%h rt=%h want 0", rs_data, rt_data);
        end
        idle();
        tick();
        exp_cnt++;
        checks++;
        if (rs_data !== 32'h0 || retired_count !== 4'(exp_cnt)) begin
            failures++;
            $display("FAIL r0_commit: got r0=%h cnt=%0d want 0 %0d", rs_data, retired_count, exp_cnt);
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b1, 1'b0, 5'd5, 32'h0000_5555, 32'h0);
        rs_addr = 5'd5;
        rt_addr = 5'd6;
        tick();
        wb_stall = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 5'd6, 32'h0000_6666, 32'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (w_rd !== 5'd5 || w_data !== 32'h0000_5555 || retired_count !== 4'(exp_cnt)) begin
                failures++;
                $display("FAIL stall_hold c%0d: got rd=%0d data=%h cnt=%0d want 5 00005555 %0d",
                         c, w_rd, w_data, retired_count, exp_cnt);
            end
            checks++;
            if (rs_data !== (BYP ? 32'h0000_5555 : 32'h0)) begin
                failures++;
                $display("FAIL stall_r5 c%0d: got %h want %h", c, rs_data, BYP ? 32'h0000_5555 : 32'h0);
            end
        end
        wb_stall = 1'b0;
        tick();
        exp_cnt++;
        checks++;
        if (rs_data !== 32'h0000_5555 || retired_count !== 4'(exp_cnt) || w_rd !== 5'd6) begin
            failures++;
            $display("FAIL stall_release: got r5=%h cnt=%0d rd=%0d want 00005555 %0d 6",
                     rs_data, retired_count, w_rd, exp_cnt);
        end
        idle();
        tick();
        exp_cnt++;
        checks++;
        if (rt_data !== 32'h0000_6666 || retired_count !== 4'(exp_cnt)) begin
            failures++;
            $display("FAIL stall_next: got r6=%h cnt=%0d want 00006666 %0d", rt_data, retired_count, exp_cnt);
        end
    endtask

    task automatic test_bubble();
        drive(1'b0, 1'b1, 1'b0, 5'd7, 32'h0000_7777, 32'h0);
        rs_addr = 5'd7;
        tick();
        checks++;
        if (w_valid !== 1'b0 || w_wreg !== 1'b0) begin
            failures++;
            $display("FAIL bubble_stage: got v=%0b w=%0b want 0 0", w_valid, w_wreg);
        end
        idle();
        tick();
        checks++;
        if (rs_data !== 32'h0 || retired_count !== 4'(exp_cnt)) begin
            failures++;
            $display("FAIL bubble_commit: got r7=%h cnt=%0d want 0 %0d", rs_data, retired_count, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'(i % 2), 5'(11 + i), 32'(32'h100 + i), 32'(32'h200 + i));
            tick();
        end
        idle();
        tick();
        exp_cnt += 3;
        for (int i = 0; i < 3; i++) begin
            rs_addr = 5'(11 + i);
            #1;
            checks++;
            if (rs_data !== ((i % 2) == 1 ? 32'(32'h200 + i) : 32'(32'h100 + i))) begin
                failures++;
                $display("FAIL b2b_r%0d: got %h", 11 + i, rs_data);
            end
        end
        checks++;
        if (retired_count !== 4'(exp_cnt)) begin
            failures++;
            $display("FAIL b2b_count: got %0d want %0d", retired_count, 4'(exp_cnt));
        end
    endtask

    task automatic test_wrap();
        @(negedge clock);
        resetn = 1'b0;
        #1;
        resetn = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 1'b0, 1'b0, 5'd1, 32'h0, 32'h0);
            tick();
        end
        idle();
        tick();
        checks++;
        if (retired_count !== 4'd1) begin
            failures++;
            $display("FAIL counter_wrap: got %0d want 1", retired_count);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        exp_cnt  = 0;
        resetn   = 1'b0;
        wb_stall = 1'b0;
        rs_addr  = 5'd0;
        rt_addr  = 5'd0;
        idle();
        #12;
        resetn = 1'b1;
        test_reset();
        test_load();
        test_r0();
        test_stall();
        test_bubble();
        test_back_to_back();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
